// File: rtl/encoder64_6_seq_pkg.sv
// Shared widths, state encoding and popcount helper for the 64-to-6 sequential encoder.
package enc64_pkg;

  localparam int VEC_W  = 64;
  localparam int CODE_W = 6;
  localparam int CNT_W  = 7;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  function automatic logic [CNT_W-1:0] popcount(input logic [VEC_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < VEC_W; i++) begin
      c = c + CNT_W'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/encoder64_6_seq_pri_enc.sv
// Combinational lowest-code priority encoder over a 64-bit vector (bit k = code k).
module pri_enc64_6
  import enc64_pkg::*;
(
  input  logic [VEC_W-1:0]  vec,
  output logic [CODE_W-1:0] code,
  output logic              any_set,
  output logic              single_set
);

  // Descending scan so the lowest set index wins.
  always_comb begin
    code = '0;
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) code = CODE_W'(i);
    end
  end

  assign any_set    = |vec;
  assign single_set = any_set && ((vec & (vec - VEC_W'(1))) == '0);

endmodule

// File: rtl/encoder64_6_seq.sv
// Sequential 64-to-6 encoder: emits the code of every set bit, lowest first.
// Optional feature macro: ENC_POPCNT_EN adds the registered popcount port cnt.
module encoder64_6_seq
  import enc64_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic [0:63] in,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [0:5]  out,
  output logic        out_last,
  output logic        zero
`ifdef ENC_POPCNT_EN
  ,
  output logic [0:6]  cnt
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // in_rdy/out_vld depend only on registered state, never on the inputs.

  state_t            state, state_d;
  logic [VEC_W-1:0]  vec, vec_d;
  logic              zero_d;
  logic [CODE_W-1:0] code;
  logic              any_set;
  logic              single_set;

  pri_enc64_6 u_pri_enc (
    .vec        (vec),
    .code       (code),
    .any_set    (any_set),
    .single_set (single_set)
  );

  // Ascending input range lands numerically, so vec[k] holds in[63-k].
  always_comb begin
    state_d = state;
    vec_d   = vec;
    zero_d  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (in_vld) begin
          vec_d   = in;
          zero_d  = (in == '0);
          state_d = (in == '0) ? ST_IDLE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (!any_set) begin
          state_d = ST_IDLE;
        end else if (out_rdy) begin
          vec_d = vec & (vec - VEC_W'(1));
          if (single_set) state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      vec   <= '0;
      zero  <= 1'b0;
    end else begin
      state <= state_d;
      vec   <= vec_d;
      zero  <= zero_d;
    end
  end

`ifdef ENC_POPCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (in_vld && state == ST_IDLE) begin
      cnt <= popcount(in);
    end
  end
`endif

  assign in_rdy   = (state == ST_IDLE);
  assign out_vld  = (state == ST_SCAN);
  assign out      = code;
  assign out_last = single_set;

endmodule

// File: tb/tb_encoder64_6_seq.sv
// Self-checking bench for encoder64_6_seq against a code-list reference model.
module tb_encoder64_6_seq;

  logic        clk;
  logic        rst_n;
  logic        in_vld;
  logic        in_rdy;
  logic [0:63] in_v;
  logic        out_vld;
  logic        out_rdy;
  logic [0:5]  out;
  logic        out_last;
  logic        zero;
`ifdef ENC_POPCNT_EN
  logic [0:6]  cnt;
`endif

  int total = 0;
  int bad   = 0;
  logic [5:0] exp_q[$];

  encoder64_6_seq dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in       (in_v),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out      (out),
    .out_last (out_last),
    .zero     (zero)
`ifdef ENC_POPCNT_EN
    ,
    .cnt      (cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference model: list of codes k with in[63-k] set, in ascending order
  task automatic build_model(input logic [0:63] v);
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      if (v[63-k]) exp_q.push_back(6'(k));
    end
  endtask

  // drive one vector and scoreboard its output stream
  // rdy_mode: 0 always ready, 1 random, 2 pattern 1,0,0,1,1 then ready
  task automatic run_vector(input logic [0:63] v, input int rdy_mode, input bit junk);
    int  w;
    int  cyc;
    int  idx;
    int  pc;
    bit  r;
    bit  pat[5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    w = 0;
    while (in_rdy !== 1'b1 && w < 20) begin
      tick();
      w++;
    end
    total++;
    if (in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL accept_wait: in_rdy=%0b required 1", in_rdy);
    end
    build_model(v);
    pc = exp_q.size();
    in_vld = 1'b1;
    in_v   = v;
    tick();
    in_vld = 1'b0;
    in_v   = {$urandom, $urandom};
`ifdef ENC_POPCNT_EN
    total++;
    if (cnt !== 7'(pc)) begin
      bad++;
      $display("FAIL cnt: got %0d required %0d", cnt, pc);
    end
`endif
    if (pc == 0) begin
      total++;
      if (zero !== 1'b1 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
        bad++;
        $display("FAIL zero_pulse: zero=%0b out_vld=%0b in_rdy=%0b required 1 0 1", zero, out_vld, in_rdy);
      end
      tick();
      total++;
      if (zero !== 1'b0 || out_vld !== 1'b0 || in_rdy !== 1'b1) begin
        bad++;
        $display("FAIL zero_after: zero=%0b out_vld=%0b in_rdy=%0b required 0 0 1", zero, out_vld, in_rdy);
      end
      return;
    end
    total++;
    if (zero !== 1'b0) begin
      bad++;
      $display("FAIL zero_nonzero: zero=%0b required 0", zero);
    end
    cyc = 0;
    idx = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      total++;
      if (out_vld !== 1'b1 || in_rdy !== 1'b0) begin
        bad++;
        $display("FAIL scan_flags: out_vld=%0b in_rdy=%0b required 1 0", out_vld, in_rdy);
      end
      total++;
      if (out !== exp_q[0]) begin
        bad++;
        $display("FAIL code: got %0d required %0d", out, exp_q[0]);
      end
      total++;
      if (out_last !== (exp_q.size() == 1)) begin
        bad++;
        $display("FAIL out_last: got %0b required %0b", out_last, (exp_q.size() == 1));
      end
      case (rdy_mode)
        0:       r = 1'b1;
        1:       r = ($urandom_range(0, 3) != 0);
        default: r = (idx < 5) ? pat[idx] : 1'b1;
      endcase
      out_rdy = r;
      if (junk) begin
        in_vld = 1'b1;
        in_v   = {$urandom, $urandom};
      end
      tick();
      in_vld = 1'b0;
      if (r) void'(exp_q.pop_front());
      cyc++;
      idx++;
    end
    out_rdy = 1'b0;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scan_timeout: codes left=%0d required 0", exp_q.size());
      exp_q.delete();
    end
    total++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL scan_end: out_vld=%0b in_rdy=%0b required 0 1", out_vld, in_rdy);
    end
  endtask

  task automatic test_reset();
    rst_n   = 1'b1;
    in_vld  = 1'b0;
    out_rdy = 1'b0;
    in_v    = '0;
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (in_rdy !== 1'b1 || out_vld !== 1'b0 || out !== 6'd0 || out_last !== 1'b0 || zero !== 1'b0) begin
      bad++;
      $display("FAIL reset_values: in_rdy=%0b out_vld=%0b out=%0d out_last=%0b zero=%0b required 1 0 0 0 0",
               in_rdy, out_vld, out, out_last, zero);
    end
`ifdef ENC_POPCNT_EN
    total++;
    if (cnt !== 7'd0) begin
      bad++;
      $display("FAIL reset_cnt: got %0d required 0", cnt);
    end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_bit();
    logic [0:63] v;
    v = '0;
    v[58] = 1'b1;
    run_vector(v, 0, 1'b0);
  endtask

  task automatic test_three_codes();
    logic [0:63] v;
    v = '0;
    v[63] = 1'b1;
    v[60] = 1'b1;
    v[0]  = 1'b1;
    run_vector(v, 0, 1'b0);
  endtask

  task automatic test_stall();
    logic [0:63] v;
    v = '0;
    v[63] = 1'b1;
    v[60] = 1'b1;
    v[0]  = 1'b1;
    run_vector(v, 2, 1'b1);
  endtask

  task automatic test_zero();
    run_vector('0, 0, 1'b0);
  endtask

  task automatic test_reset_mid_scan();
    logic [0:63] v;
    v = '1;
    in_vld = 1'b1;
    in_v   = v;
    tick();
    in_vld  = 1'b0;
    out_rdy = 1'b1;
`ifdef ENC_POPCNT_EN
    total++;
    if (cnt !== 7'd64) begin
      bad++;
      $display("FAIL cnt_all_ones: got %0d required 64", cnt);
    end
`endif
    for (int i = 0; i < 10; i++) begin
      total++;
      if (out !== 6'(i) || out_vld !== 1'b1) begin
        bad++;
        $display("FAIL pre_reset_code: got %0d vld=%0b required %0d vld=1", out, out_vld, i);
      end
      tick();
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1 || out !== 6'd0 || out_last !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: out_vld=%0b in_rdy=%0b out=%0d out_last=%0b required 0 1 0 0",
               out_vld, in_rdy, out, out_last);
    end
    out_rdy = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    total++;
    if (out_vld !== 1'b0 || in_rdy !== 1'b1) begin
      bad++;
      $display("FAIL post_reset: out_vld=%0b in_rdy=%0b required 0 1", out_vld, in_rdy);
    end
    v = '0;
    v[56] = 1'b1;
    run_vector(v, 0, 1'b0);
  endtask

  task automatic test_round_trip();
    logic [0:63] v;
    for (int k = 0; k < 64; k++) begin
      v = '0;
      v[63-k] = 1'b1;
      run_vector(v, 0, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [0:63] v;
    for (int n = 0; n < 24; n++) begin
      v = {$urandom, $urandom};
      if (n % 3 == 1) v = v & {$urandom, $urandom} & {$urandom, $urandom};
      run_vector(v, 1, n[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_three_codes();
    test_stall();
    test_zero();
    test_reset_mid_scan();
    test_round_trip();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
